// File: rtl/logic_vec_sequencer_pkg.sv
// Shared types and sizing for the logic-vector sequencer: FSM states, widths
// and stock truth tables for common 3-input gates.
package logic_vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC  = 8;
  localparam int VEC_W    = 3;
  localparam int ERR_W    = 4;
  localparam int SETTLE_W = 4;

  // Bit k is the gate output for input vector k = {a,b,c}
  localparam logic [NUM_VEC-1:0] TT_OR3  = 8'hFE;
  localparam logic [NUM_VEC-1:0] TT_AND3 = 8'h80;
  localparam logic [NUM_VEC-1:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/logic_vec_sequencer_if.sv
// Board-side bundle of the sequencer: start button, stimulus to the block
// under test, its response, and the result/status indicators.
interface logic_vec_sequencer_if;
  import logic_vec_pkg::*;

  logic               start;
  logic               y_i;
  logic               a_o;
  logic               b_o;
  logic               c_o;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] fail_vec;
  logic [ERR_W-1:0]   err_cnt;

  modport master (
    input  start, y_i,
    output a_o, b_o, c_o, busy, done, pass, fail_vec, err_cnt
  );

  modport slave (
    output start, y_i,
    input  a_o, b_o, c_o, busy, done, pass, fail_vec, err_cnt
  );

endinterface

// File: rtl/logic_vec_sequencer_vec_settle_timer.sv
// Loadable up-counter that flags when it has reached a programmable terminal
// value; used to hold each test vector for the settle time.
module vec_settle_timer #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  input  logic [SETTLE_W-1:0] term,
  output logic                tc
);

  logic [SETTLE_W-1:0] cnt;

  assign tc = (cnt == term);

  // Counting stops at the terminal value so a long hold can never wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !tc) begin
      cnt <= cnt + SETTLE_W'(1);
    end
  end

endmodule

// File: rtl/logic_vec_sequencer.sv
// Walks all 8 input vectors of a 3-input logic block, samples its output after
// a settle time and scores it against an expected truth table.
module logic_vec_sequencer
  import logic_vec_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECT_TT     = TT_OR3,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_vec_sequencer_if.master bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_TERM = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [NUM_VEC-1:0] fail_vec_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_tc;

  // The driven vector is the vector register itself, so a/b/c stay registered
  assign bus.a_o      = vec[2];
  assign bus.b_o      = vec[1];
  assign bus.c_o      = vec[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_vec = fail_vec_q;
  assign bus.err_cnt  = err_cnt_q;

  assign tmr_load = ((state == IDLE) && bus.start) ||
                    ((state == SAMPLE) && (vec != LAST_VEC));
  assign tmr_en   = (state == SETTLE);

  vec_settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val ('0),
    .en       (tmr_en),
    .term     (SETTLE_TERM),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            fail_vec_q <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            vec        <= '0;
            busy_q     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (bus.y_i != EXPECT_TT[vec]) begin
            fail_vec_q[vec] <= 1'b1;
            err_cnt_q       <= err_cnt_q + ERR_W'(1);
          end
          // Exit on the last vector before any increment, so vec never wraps
          if (vec == LAST_VEC) begin
            state <= DONE;
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (err_cnt_q == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_vec_sequencer.sv
// Bench for logic_vec_sequencer: two instances (OR3/settle 2 and XOR3/settle 1)
// driven by modelled logic blocks whose truth tables are chosen per run.
module tb_logic_vec_sequencer;
  import logic_vec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st [2];
  logic [7:0] tt [2];
  int         tests = 0;
  int         fails = 0;

  localparam logic [7:0] EXP_TT [2] = '{TT_OR3, TT_XOR3};
  localparam int         SC     [2] = '{2, 1};

  logic_vec_sequencer_if vif0 ();
  logic_vec_sequencer_if vif1 ();

  assign vif0.start = st[0];
  assign vif1.start = st[1];
  assign vif0.y_i   = tt[0][{vif0.a_o, vif0.b_o, vif0.c_o}];
  assign vif1.y_i   = tt[1][{vif1.a_o, vif1.b_o, vif1.c_o}];

  logic_vec_sequencer dut0 (
    .clk (clk),
    .rst (rst),
    .bus (vif0)
  );

  logic_vec_sequencer #(
    .EXPECT_TT     (TT_XOR3),
    .SETTLE_CYCLES (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (vif1)
  );

  // Packed snapshot: {vec[17:15], busy[14], done[13], pass[12], fail_vec[11:4], err_cnt[3:0]}
  function automatic logic [17:0] obs(int i);
    if (i == 0)
      return {vif0.a_o, vif0.b_o, vif0.c_o, vif0.busy, vif0.done, vif0.pass,
              vif0.fail_vec, vif0.err_cnt};
    else
      return {vif1.a_o, vif1.b_o, vif1.c_o, vif1.busy, vif1.done, vif1.pass,
              vif1.fail_vec, vif1.err_cnt};
  endfunction

  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full run on instance i with the block under test behaving as 'model'.
  // Returns at the negedge where done is visible. repulse<0 disables the
  // mid-run start pulse; tail>0 then checks that the sequencer stays idle.
  task automatic run(int i, logic [7:0] model, int repulse, int tail, string tag);
    int          d;
    int          ev;
    logic [7:0]  efv;
    logic [17:0] o;
    d   = 8 * (SC[i] + 1) + 1;
    efv = model ^ EXP_TT[i];
    tt[i] = model;
    st[i] = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= d; n++) begin
      @(negedge clk);
      o = obs(i);
      if (n == 0) begin
        st[i] = 1'b0;
        chk({tag, "_clear"}, {20'd0, o[12:0]}, 32'd0);
      end
      if (n == repulse)     st[i] = 1'b1;
      if (n == repulse + 1) st[i] = 1'b0;
      ev = n / (SC[i] + 1);
      if (ev > 7) ev = 7;
      chk($sformatf("%s_vec%0d", tag, n), {29'd0, o[17:15]}, ev);
      chk($sformatf("%s_busy%0d", tag, n), {31'd0, o[14]}, {31'd0, n < d});
      chk($sformatf("%s_done%0d", tag, n), {31'd0, o[13]}, {31'd0, n == d});
    end
    chk({tag, "_failvec"}, {24'd0, o[11:4]}, {24'd0, efv});
    chk({tag, "_errcnt"}, {28'd0, o[3:0]}, $countones(efv));
    chk({tag, "_pass"}, {31'd0, o[12]}, {31'd0, efv == 8'h00});
    for (int k = 0; k < tail; k++) begin
      @(negedge clk);
      o = obs(i);
      chk({tag, "_idle"}, {30'd0, o[14:13]}, 32'd0);
    end
  endtask

  initial begin
    logic [17:0] o;
    int          inst;
    st[0] = 1'b0; st[1] = 1'b0;
    tt[0] = TT_OR3; tt[1] = TT_OR3;

    // Reset state
    #1;
    chk("rst_inst0", {14'd0, obs(0)}, 32'd0);
    chk("rst_inst1", {14'd0, obs(1)}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_inst0", {14'd0, obs(0)}, 32'd0);

    // Directed runs on the OR3 / settle-2 instance
    run(0, TT_OR3,  -1, 2, "or3_ok");
    run(0, 8'h00,   -1, 2, "y_zero");
    run(0, TT_XOR3, -1, 2, "xor_vs_or");
    run(0, TT_OR3,   7, 3, "repulse");

    // Reset during SETTLE of vector 4
    tt[0] = 8'h00;
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (12) @(negedge clk);
    o = obs(0);
    chk("pre_rst_vec", {29'd0, o[17:15]}, 32'd4);
    rst = 1'b1;
    #1;
    chk("async_rst", {14'd0, obs(0)}, 32'd0);
    @(posedge clk); #1;
    chk("rst_next_cycle", {14'd0, obs(0)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      o = obs(0);
      chk("post_rst_quiet", {30'd0, o[14:13]}, 32'd0);
    end
    run(0, TT_OR3, -1, 1, "fresh_run");

    // Settle-1 instance: shorter period
    run(1, TT_XOR3, -1, 1, "s1_xor_ok");
    run(1, TT_OR3,   4, 2, "s1_or_vs_xor");

    // Back-to-back: failing run then start re-asserted right after done
    run(0, 8'h00,  -1, 0, "b2b_first");
    run(0, TT_OR3, -1, 1, "b2b_second");

    // Randomised block behaviour on either instance
    for (int r = 0; r < 6; r++) begin
      inst = int'($urandom_range(0, 1));
      run(inst, 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
          1, $sformatf("rnd%0d_i%0d", r, inst));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
